uart_tx: RTL

UART transmitter. It serialises one byte per valid/ready handshake into an 8-N-1 frame (configurable stop bits) on a single TX line. It is the transmit-side counterpart of uart_rx and uses the same ClkFreq/BaudRate parameterisation. It is instantiated in top beside uart_rx and drives o_uart_tx, for echo and loopback of received bytes.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_gen.sv | 57 +++++
 rtl/uart_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmitter and receiver:
//                FSM state encoding, frame-level constants and the
//                cycles-per-bit computation.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame FSM states. PARITY is only entered when parity is built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int   DataBits   = 8;
    localparam logic StartLevel = 1'b0;
    localparam logic StopLevel  = 1'b1;

    // Integer truncation: the bit period is rounded down.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period counter. Counts 0..ClksPerBit-1 and emits a
//                one-cycle tick on the last count, then restarts from 0.
//                With i_half set the tick comes at ClksPerBit/2-1 instead,
//                which a receiver uses to find the middle of a start bit.
//  Ports       : i_clk      system clock, rising edge
//                i_rstn     asynchronous active-low reset
//                i_restart  hold counter at 0 (no tick while asserted)
//                i_half     tick at half period instead of full period
//                o_tick     one-cycle pulse at end of the (half) period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int ClksPerBit = 86
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_restart,
    input  logic i_half,
    output logic o_tick
);

    localparam int C_CNT_W = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [C_CNT_W-1:0] C_FULL_AT = C_CNT_W'(ClksPerBit - 1);
    localparam logic [C_CNT_W-1:0] C_HALF_AT = C_CNT_W'(ClksPerBit / 2 - 1);

    logic [C_CNT_W-1:0] cnt_q;
    logic [C_CNT_W-1:0] cnt_d;
    logic [C_CNT_W-1:0] w_target;
    logic               w_tick;

    always_comb begin
        w_target = i_half ? C_HALF_AT : C_FULL_AT;
        w_tick   = !i_restart && (cnt_q == w_target);
        // Clearing on the tick keeps the count aligned to bit boundaries,
        // so it can never run past the terminal value mid-bit.
        if (i_restart || w_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + C_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter. Serialises one byte per valid/ready
//                handshake into a start / 8 data (LSB first) / [parity] /
//                stop frame on a registered, glitch-free TX line.
//                Optional even parity is built in when the macro
//                UART_TX_PARITY_EN is defined.
//  Ports       : i_clk       system clock, rising edge
//                i_rstn      asynchronous active-low reset
//                i_tx_valid  byte on i_tx_byte offered for transmission
//                i_tx_byte   data byte, sampled on the handshake edge
//                o_tx_ready  high while a new byte can be accepted
//                o_tx_done   one-cycle pulse at end of the last stop bit
//                o_tx        serial line, idles high
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int ClkFreq  = 10_000_000,
    parameter int BaudRate = 115200,
    parameter int StopBits = 1
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_done,
    output logic       o_tx
);

    localparam int ClksPerBit = clks_per_bit(ClkFreq, BaudRate);

    if (ClksPerBit < 2 || (StopBits != 1 && StopBits != 2)) begin : g_param_check
        $error("uart_tx: ClksPerBit must be >= 2 and StopBits must be 1 or 2");
    end

    uart_state_e state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic w_tick;
    logic w_restart;

    // Counter is held at zero while idle so the start bit gets a full period
    // measured from the handshake edge.
    assign w_restart = (state_q == IDLE);

    uart_baud_gen #(
        .ClksPerBit (ClksPerBit)
    ) u_baud_gen (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_restart (w_restart),
        .i_half    (1'b0),
        .o_tick    (w_tick)
    );

    // tx_d is only changed on the handshake or on a tick, which keeps the
    // registered line stable for whole bit periods.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_tx_valid) begin
                    shift_d   = i_tx_byte;
                    tx_d      = StartLevel;
                    bit_idx_d = 3'd0;
                    state_d   = START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^i_tx_byte;
`endif
                end
            end
            START: begin
                if (w_tick) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (bit_idx_q == 3'(DataBits - 1)) begin
                        bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        tx_d      = parity_q;
                        state_d   = PARITY;
`else
                        tx_d      = StopLevel;
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    tx_d    = StopLevel;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // bit_idx is reused to count stop bits.
                if (w_tick) begin
                    if (bit_idx_q == 3'(StopBits - 1)) begin
                        bit_idx_d = 3'd0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                tx_d    = StopLevel;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign o_tx_ready = (state_q == IDLE);
    assign o_tx_done  = done_q;
    assign o_tx       = tx_q;

endmodule
`default_nettype wire
